// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the inverse key scheduler: round count, Rcon
// table, scheduler state encoding and 32-bit word helpers.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_EMIT = 2'd2
    } state_e;

    // Round constant for round 1..10, already placed in the top byte of the word.
    function automatic logic [31:0] rcon_word(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h000000};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Word 0 is the most significant 32 bits (FIPS-197 byte order).
    function automatic logic [31:0] key_word(input logic [127:0] key, input int idx);
        return key[127-32*idx -: 32];
    endfunction

    function automatic logic [127:0] pack_words(input logic [31:0] w0, input logic [31:0] w1,
                                                input logic [31:0] w2, input logic [31:0] w3);
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational byte lookup.
module aes_sbox (
    input  logic [7:0] iByte,
    output logic [7:0] oByte
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign oByte = SBOX[iByte];

endmodule

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 inverse key scheduler: expands the cipher key forward to round
// key 10, then walks the schedule backwards, handing out keys 10..0 on valid/ready.
module aes_inv_key_sched
    import aes_pkg::*;
#(
    parameter int NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] iKey,
    input  logic         iStart,
    output logic         oBusy,
    output logic [127:0] oRoundKey,
    output logic [3:0]   oRoundIdx,
    output logic         oKeyValid,
    input  logic         iKeyReady,
    output logic         oDone
);

    if (NR != 10) begin : g_bad_nr
        $error("aes_inv_key_sched supports only NR = 10");
    end

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         valid_q, valid_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  inv_w1, inv_w2, inv_w3;
    logic [31:0]  sub_in, sub_rot, sub_out, mix_word;
    logic [3:0]   rcon_idx;
    logic [127:0] fwd_key, inv_key;
    logic         xfer;

    assign w0 = key_word(key_q, 0);
    assign w1 = key_word(key_q, 1);
    assign w2 = key_word(key_q, 2);
    assign w3 = key_word(key_q, 3);

    assign inv_w3 = w3 ^ w2;
    assign inv_w2 = w2 ^ w1;
    assign inv_w1 = w1 ^ w0;

    // One SubWord path serves both directions; stepping back needs the recovered w3'.
    assign sub_in  = (state_q == ST_EMIT) ? inv_w3 : w3;
    assign sub_rot = rot_word(sub_in);

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .iByte (sub_rot[8*b +: 8]),
            .oByte (sub_out[8*b +: 8])
        );
    end

    // In FWD cnt holds the round just completed; in EMIT it holds the round on the output.
    assign rcon_idx = (state_q == ST_FWD) ? cnt_q + 4'd1 : cnt_q;
    assign mix_word = sub_out ^ rcon_word(rcon_idx);

    always_comb begin
        logic [31:0] f0, f1, f2, f3;
        f0      = w0 ^ mix_word;
        f1      = w1 ^ f0;
        f2      = w2 ^ f1;
        f3      = w3 ^ f2;
        fwd_key = pack_words(f0, f1, f2, f3);
        inv_key = pack_words(w0 ^ mix_word, inv_w1, inv_w2, inv_w3);
    end

    assign xfer = valid_q & iKeyReady;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    key_d   = iKey;
                    cnt_d   = 4'd0;
                    state_d = ST_FWD;
                end
            end
            ST_FWD: begin
                key_d = fwd_key;
                if (cnt_q == 4'(NR - 1)) begin
                    cnt_d   = 4'(NR);
                    valid_d = 1'b1;
                    state_d = ST_EMIT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_EMIT: begin
                if (xfer) begin
                    if (cnt_q == 4'd0) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        key_d = inv_key;
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the 128-bit key
    // register is reset too, so oRoundKey reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign oBusy     = (state_q != ST_IDLE);
    assign oRoundKey = key_q;
    assign oRoundIdx = valid_q ? cnt_q : 4'd0;
    assign oKeyValid = valid_q;
    assign oDone     = done_q;

endmodule
